// File: rtl/dct_pkg.sv
// Shared types and default sizing for the 32-point DCT sequencing controller.
package dct_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam int DCT_N       = 32;
  localparam int DCT_LATENCY = 6;
  localparam int BUF_DEPTH   = 8;

endpackage

// File: rtl/dct32_seq_ptr.sv
// Write/read pointer pair for the result buffer; an extra wrap bit separates full from empty.
module dct32_seq_ptr #(
  parameter int AW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          wr_inc,
  input  logic          rd_inc,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] raddr,
  output logic          full,
  output logic          empty
);

  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic [AW:0] occupancy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_inc) wr_ptr <= wr_ptr + 1'b1;
      if (rd_inc) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  assign occupancy = wr_ptr - rd_ptr;
  assign waddr     = wr_ptr[AW-1:0];
  assign raddr     = rd_ptr[AW-1:0];
  assign full      = (occupancy == {1'b1, {AW{1'b0}}});
  assign empty     = (occupancy == '0);

endmodule

// File: rtl/dct32_seq_ctrl.sv
// Frame sequencer for the 32-point DCT: credit-limited issue, latency tracking, result buffer handshake.
// Optional statistics counters are enabled by defining DCT32_SEQ_STATS_EN.
//
// state | meaning
// IDLE  | waiting for start; counters and pointers parked
// RUN   | issuing rows while row budget and buffer credit allow
// DRAIN | all rows issued; waiting for in-flight and buffered results to leave
module dct32_seq_ctrl
  import dct_pkg::*;
#(
  parameter int LATENCY = DCT_LATENCY,
  parameter int DEPTH   = BUF_DEPTH,
  parameter int ROWS    = DCT_N,
  parameter int AW      = $clog2(DEPTH),
  parameter int RW      = $clog2(ROWS)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          dct_load,
  output logic          buf_we,
  output logic [AW-1:0] buf_waddr,
  output logic [AW-1:0] buf_raddr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_row,
  output logic          out_last,
  output logic          busy,
  output logic          done
`ifdef DCT32_SEQ_STATS_EN
  ,
  output logic [31:0]   stat_issued,
  output logic [31:0]   stat_stall
`endif
);

  localparam logic [RW:0]   ROWS_C     = (RW+1)'(ROWS);
  localparam logic [RW:0]   LAST_ISSUE = (RW+1)'(ROWS - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(ROWS - 1);
  localparam logic [AW:0]   DEPTH_C    = (AW+1)'(DEPTH);

  state_t              state, state_nxt;
  logic [RW:0]         issued_rows;
  logic [AW:0]         reserved;
  logic [LATENCY-1:0]  vpipe;
  logic                issue, pop, clr, frame_start;
  logic                buf_full, buf_empty;

  assign frame_start = (state == IDLE) & start & ~abort;
  assign clr         = abort | frame_start;

  // reserved covers in-flight plus buffered rows, so buf_full is only a backstop
  assign in_ready  = (state == RUN) & (issued_rows < ROWS_C) & (reserved < DEPTH_C) & ~buf_full;
  assign dct_load  = in_valid & in_ready;
  assign issue     = dct_load;
  assign buf_we    = vpipe[LATENCY-1];
  assign out_valid = ~buf_empty;
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & (out_row == LAST_ROW);
  assign busy      = (state != IDLE);

  dct32_seq_ptr #(.AW(AW)) u_ptr (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr),
    .wr_inc (buf_we),
    .rd_inc (pop),
    .waddr  (buf_waddr),
    .raddr  (buf_raddr),
    .full   (buf_full),
    .empty  (buf_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    done      = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = RUN;
        RUN:     if (issue && issued_rows == LAST_ISSUE) state_nxt = DRAIN;
        DRAIN: begin
          if (reserved == '0) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issued_rows <= '0;
      reserved    <= '0;
      vpipe       <= '0;
      out_row     <= '0;
    end else if (clr) begin
      issued_rows <= '0;
      reserved    <= '0;
      vpipe       <= '0;
      out_row     <= '0;
    end else begin
      vpipe <= {vpipe[LATENCY-2:0], issue};
      if (issue) issued_rows <= issued_rows + 1'b1;
      if (pop)   out_row     <= out_row + 1'b1;
      case ({issue, pop})
        2'b10:   reserved <= reserved + 1'b1;
        2'b01:   reserved <= reserved - 1'b1;
        default: reserved <= reserved;
      endcase
    end
  end

`ifdef DCT32_SEQ_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else if (frame_start) begin
      stat_issued <= '0;
      stat_stall  <= '0;
    end else begin
      if (issue && stat_issued != '1) stat_issued <= stat_issued + 1'b1;
      if (state == RUN && in_valid && !in_ready && stat_stall != '1)
        stat_stall <= stat_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_dct32_seq_ctrl.sv
// Directed and randomised scenario bench for dct32_seq_ctrl (stats checks when DCT32_SEQ_STATS_EN is defined).
module tb_dct32_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, abort, in_valid, out_ready;
  logic       in_ready, dct_load, buf_we, out_valid, out_last, busy, done;
  logic [2:0] buf_waddr, buf_raddr;
  logic [4:0] out_row;
`ifdef DCT32_SEQ_STATS_EN
  logic [31:0] stat_issued, stat_stall;
`endif

  dct32_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_ready(in_ready), .dct_load(dct_load),
    .buf_we(buf_we), .buf_waddr(buf_waddr), .buf_raddr(buf_raddr),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_last(out_last), .busy(busy), .done(done)
`ifdef DCT32_SEQ_STATS_EN
    , .stat_issued(stat_issued), .stat_stall(stat_stall)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc_n = 0;
  int loads, writes, pops, dones, credit_viol, first_load, last_load, first_ov;
  int rowq[$];
  int lastq[$];

  task automatic clr_counts();
    loads = 0; writes = 0; pops = 0; dones = 0; credit_viol = 0;
    first_load = -1; last_load = -1; first_ov = -1;
    rowq.delete(); lastq.delete();
  endtask

  // samples the cycle's outputs away from the edge, then advances one clock
  task automatic cyc();
    #1;
    if (dct_load) begin
      if (loads - pops >= 8) credit_viol++;
      if (first_load < 0) first_load = cyc_n;
      last_load = cyc_n;
      loads++;
    end
    if (buf_we) writes++;
    if (writes - pops > 8) credit_viol++;
    if (out_valid && first_ov < 0) first_ov = cyc_n;
    if (out_valid && out_ready) begin
      rowq.push_back(int'(out_row));
      pops++;
      if (out_last) lastq.push_back(int'(out_row));
    end
    if (done) dones++;
    cyc_n++;
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  function automatic int order_bad();
    int bad = 0;
    if (rowq.size() != 32) bad++;
    foreach (rowq[i]) if (rowq[i] != i) bad++;
    return bad;
  endfunction

  task automatic run_to_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      cyc();
      if (loads >= 32) in_valid = 1'b0;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; abort = 0; in_valid = 0; out_ready = 0;
    #12;
    checks++; if ({in_ready, dct_load, buf_we, out_valid, out_last, busy, done} !== 7'b0) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000000", {in_ready, dct_load, buf_we, out_valid, out_last, busy, done}); end
    checks++; if ({buf_waddr, buf_raddr, out_row} !== 11'd0) begin
      errors++; $display("FAIL reset_addr: got waddr=%0d raddr=%0d row=%0d expected 0", buf_waddr, buf_raddr, out_row); end
    @(posedge clk); #1; rst = 1'b0;
    cyc();
  endtask

  task automatic test_full_frame();
    clr_counts(); in_valid = 0; out_ready = 1;
    pulse_start();
    in_valid = 1'b1;
    run_to_done(200);
    checks++; if (loads !== 32) begin errors++; $display("FAIL full_loads: got %0d expected 32", loads); end
    checks++; if (last_load - first_load !== 31) begin
      errors++; $display("FAIL full_consecutive: got span %0d expected 31", last_load - first_load); end
    checks++; if (first_ov - first_load !== 7) begin
      errors++; $display("FAIL full_latency: got %0d expected 7", first_ov - first_load); end
    checks++; if (order_bad() !== 0) begin
      errors++; $display("FAIL full_order: got %0d bad rows expected 0", order_bad()); end
    checks++; if (lastq.size() !== 1 || lastq[0] !== 31) begin
      errors++; $display("FAIL full_last: got %0d last flags expected 1 on row 31", lastq.size()); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_after_done: got %b expected 0", busy); end
    cyc();
    checks++; if (dones !== 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", dones); end
  endtask

  task automatic test_backpressure();
    clr_counts(); in_valid = 0; out_ready = 0;
    pulse_start();
    in_valid = 1'b1;
    repeat (40) cyc();
    checks++; if (loads !== 8) begin errors++; $display("FAIL bp_loads: got %0d expected 8", loads); end
    checks++; if (writes !== 8) begin errors++; $display("FAIL bp_writes: got %0d expected 8", writes); end
    checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_hold: got in_ready=%b out_valid=%b expected 0 1", in_ready, out_valid); end
    out_ready = 1'b1;
    run_to_done(300);
    checks++; if (loads !== 32) begin errors++; $display("FAIL bp_total_loads: got %0d expected 32", loads); end
    checks++; if (order_bad() !== 0) begin errors++; $display("FAIL bp_order: got %0d bad rows expected 0", order_bad()); end
    checks++; if (credit_viol !== 0 || dones !== 1) begin
      errors++; $display("FAIL bp_credit_done: got viol=%0d done=%0d expected 0 1", credit_viol, dones); end
  endtask

  task automatic test_random();
    int frames = 300, timeouts = 0, bad = 0, viol = 0, done_tot = 0, n;
    for (int f = 0; f < frames; f++) begin
      clr_counts(); in_valid = 0; out_ready = 0;
      pulse_start();
      n = 0;
      while (dones == 0 && n < 2000) begin
        in_valid  = 1'($urandom_range(0, 1));
        out_ready = 1'($urandom_range(0, 1));
        cyc(); n++;
      end
      if (dones == 0) timeouts++;
      if (order_bad() != 0) bad++;
      viol += credit_viol;
      done_tot += dones;
    end
    in_valid = 0;
    checks++; if (timeouts !== 0) begin errors++; $display("FAIL rand_timeout: got %0d expected 0", timeouts); end
    checks++; if (bad !== 0) begin errors++; $display("FAIL rand_order: got %0d bad frames expected 0", bad); end
    checks++; if (viol !== 0) begin errors++; $display("FAIL rand_credit: got %0d violations expected 0", viol); end
    checks++; if (done_tot !== frames) begin errors++; $display("FAIL rand_done: got %0d expected %0d", done_tot, frames); end
  endtask

  task automatic test_abort();
    int n = 0, ov_bad = 0;
    clr_counts(); in_valid = 0; out_ready = 0;
    pulse_start();
    in_valid = 1'b1;
    while (loads < 5 && n < 20) begin cyc(); n++; end
    in_valid = 1'b0;
    while (writes < 2 && n < 40) begin cyc(); n++; end
    checks++; if (out_valid !== 1'b1 || writes !== 2) begin
      errors++; $display("FAIL abort_pre: got out_valid=%b writes=%0d expected 1 2", out_valid, writes); end
    abort = 1'b1; cyc(); abort = 1'b0;
    checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL abort_next: got busy=%b out_valid=%b expected 0 0", busy, out_valid); end
    writes = 0;
    repeat (10) begin cyc(); if (out_valid) ov_bad++; end
    checks++; if (writes !== 0 || ov_bad !== 0) begin
      errors++; $display("FAIL abort_quiet: got writes=%0d ov=%0d expected 0 0", writes, ov_bad); end
    checks++; if (dones !== 0) begin errors++; $display("FAIL abort_no_done: got %0d expected 0", dones); end
    clr_counts(); out_ready = 1'b1;
    pulse_start();
    in_valid = 1'b1;
    run_to_done(200);
    checks++; if (loads !== 32 || order_bad() !== 0 || dones !== 1) begin
      errors++; $display("FAIL abort_restart: got loads=%0d bad=%0d done=%0d expected 32 0 1", loads, order_bad(), dones); end
    checks++; if (first_ov - first_load !== 7) begin
      errors++; $display("FAIL abort_restart_latency: got %0d expected 7", first_ov - first_load); end
  endtask

  task automatic test_start_ignored();
    int n = 0;
    bit fired = 0;
    clr_counts(); in_valid = 0; out_ready = 1;
    pulse_start();
    in_valid = 1'b1;
    while (dones == 0 && n < 200) begin
      if (loads == 10 && !fired) begin start = 1'b1; fired = 1; end
      cyc(); start = 1'b0;
      if (loads >= 32) in_valid = 1'b0;
      n++;
    end
    checks++; if (loads !== 32 || order_bad() !== 0 || dones !== 1) begin
      errors++; $display("FAIL start_ignored: got loads=%0d bad=%0d done=%0d expected 32 0 1", loads, order_bad(), dones); end
  endtask

  task automatic test_start_abort();
    clr_counts(); in_valid = 0; out_ready = 1;
    start = 1'b1; abort = 1'b1; cyc(); start = 1'b0; abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
    in_valid = 1'b1;
    repeat (5) cyc();
    in_valid = 1'b0;
    checks++; if (loads !== 0) begin errors++; $display("FAIL start_abort_loads: got %0d expected 0", loads); end
  endtask

  task automatic test_async_reset();
    int n = 0;
    clr_counts(); in_valid = 0; out_ready = 1;
    pulse_start();
    in_valid = 1'b1;
    while (loads < 32 && n < 100) begin cyc(); n++; end
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) cyc();
    checks++; if (busy !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL arst_pre: got busy=%b out_valid=%b expected 1 1", busy, out_valid); end
    #2; rst = 1'b1; #1;
    checks++; if ({in_ready, dct_load, buf_we, out_valid, out_last, busy, done} !== 7'b0) begin
      errors++; $display("FAIL arst_flags: got %b expected 0000000", {in_ready, dct_load, buf_we, out_valid, out_last, busy, done}); end
    checks++; if ({buf_waddr, buf_raddr, out_row} !== 11'd0) begin
      errors++; $display("FAIL arst_addr: got waddr=%0d raddr=%0d row=%0d expected 0", buf_waddr, buf_raddr, out_row); end
    @(posedge clk); #1; rst = 1'b0; out_ready = 1'b1;
    cyc();
  endtask

`ifdef DCT32_SEQ_STATS_EN
  task automatic test_stats();
    int n = 0;
    clr_counts(); in_valid = 0; out_ready = 0;
    pulse_start();
    in_valid = 1'b1;
    while (loads < 8 && n < 20) begin cyc(); n++; end
    repeat (9) cyc();
    out_ready = 1'b1;
    run_to_done(200);
    checks++; if (stat_issued !== 32'd32) begin errors++; $display("FAIL stat_issued: got %0d expected 32", stat_issued); end
    checks++; if (stat_stall !== 32'd10) begin errors++; $display("FAIL stat_stall: got %0d expected 10", stat_stall); end
  endtask
`endif

  initial begin
    #900000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_backpressure();
    test_abort();
    test_start_ignored();
    test_start_abort();
    test_async_reset();
`ifdef DCT32_SEQ_STATS_EN
    test_stats();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
